// File: rtl/hdmi_cfg_seq_pkg.sv
// Shared types and constants for the HDMI bridge boot-time configuration sequencer.
package hdmi_cfg_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_HOLD,
    S_RST_WAIT,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_RSP,
    S_DELAY,
    S_DONE,
    S_ERROR
  } cfg_state_e;

  localparam logic [15:0] TBL_END     = 16'hFFFF;
  localparam logic [7:0]  TBL_DLY_TAG = 8'hFE;
  localparam logic        DEV_RX      = 1'b0;
  localparam logic        DEV_TX      = 1'b1;

endpackage

// File: rtl/hdmi_cfg_seq_if.sv
// Command/response bus between the config sequencer (master) and the IIC byte engine (slave).
interface hdmi_cfg_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       cmd_rd;
  logic       rsp_valid;
  logic       rsp_nack;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_dev, cmd_reg, cmd_wdata, cmd_rd,
    input  cmd_ready, rsp_valid, rsp_nack, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_dev, cmd_reg, cmd_wdata, cmd_rd,
    output cmd_ready, rsp_valid, rsp_nack, rsp_rdata
  );
endinterface

// File: rtl/hdmi_cfg_seq_ms_timer.sv
// Millisecond timer: free-running prescaler plus ms down-counter; load restarts both.
module hdmi_cfg_seq_ms_timer #(
  parameter int unsigned TICKS = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_ms_i,
  output logic       expired_o,
  output logic       tick_o
);
  localparam int unsigned PW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [PW-1:0] pre_q;
  logic [7:0]    ms_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (load_i) begin
      pre_q <= PW'(TICKS - 1);
      ms_q  <= load_ms_i;
    end else if (pre_q == '0) begin
      pre_q <= PW'(TICKS - 1);
      if (ms_q != '0) ms_q <= ms_q - 1'b1;
    end else begin
      pre_q <= pre_q - 1'b1;
    end
  end

  assign tick_o    = (pre_q == '0);
  assign expired_o = (ms_q == '0);
endmodule

// File: rtl/hdmi_cfg_seq.sv
// HDMI RX/TX bridge boot sequencer: chip reset, per-device register table walk, IIC writes with retry.
// Optional CFG_READBACK_EN: read back every written register and retry on data mismatch.
module hdmi_cfg_seq
  import hdmi_cfg_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 10_000_000,
  parameter int unsigned RST_HOLD_MS = 10,
  parameter int unsigned RST_WAIT_MS = 50,
  parameter int unsigned TBL_AW      = 8,
  parameter int unsigned RETRY_MAX   = 3,
  parameter logic [6:0]  RX_DEV_ADDR = 7'h56,
  parameter logic [6:0]  TX_DEV_ADDR = 7'h59
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  output logic              rstn_out,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  hdmi_cfg_seq_if.master    bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_idx,
  output logic              led_int
);
  localparam int unsigned       TICKS     = CLK_HZ / 1000;
  localparam int unsigned       RW        = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [TBL_AW-1:0] DEV1_BASE = {1'b1, {(TBL_AW-1){1'b0}}};

  cfg_state_e        state_q, state_d;
  logic [TBL_AW-1:0] addr_q, addr_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        val_q, val_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TBL_AW-1:0] err_idx_q, err_idx_d;
  logic [7:0]        led_cnt_q;
  logic              led_q;
  logic              tmr_load, tmr_expired, ms_tick;
  logic [7:0]        tmr_ms;
  logic              kick, adv, tbl_done, fail, last_slot;
`ifdef CFG_READBACK_EN
  logic              rd_q, rd_d;
`endif

  hdmi_cfg_seq_ms_timer #(.TICKS(TICKS)) u_timer (
    .clk      (sys_clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .load_ms_i(tmr_ms),
    .expired_o(tmr_expired),
    .tick_o   (ms_tick)
  );

  assign last_slot = &addr_q[TBL_AW-2:0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    val_d     = val_q;
    retry_d   = retry_q;
    err_idx_d = err_idx_q;
    tmr_load  = 1'b0;
    tmr_ms    = '0;
    kick      = 1'b0;
    adv       = 1'b0;
    tbl_done  = 1'b0;
    fail      = 1'b0;
`ifdef CFG_READBACK_EN
    rd_d      = rd_q;
`endif
    case (state_q)
      S_IDLE:     kick = 1'b1;
      S_RST_HOLD: if (tmr_expired) begin
        state_d  = S_RST_WAIT;
        tmr_load = 1'b1;
        tmr_ms   = 8'(RST_WAIT_MS);
      end
      S_RST_WAIT: if (tmr_expired) state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        if (tbl_data == TBL_END) begin
          tbl_done = 1'b1;
        end else if (tbl_data[15:8] == TBL_DLY_TAG) begin
          state_d  = S_DELAY;
          tmr_load = 1'b1;
          tmr_ms   = tbl_data[7:0];
        end else begin
          reg_d   = tbl_data[15:8];
          val_d   = tbl_data[7:0];
          retry_d = '0;
          state_d = S_ISSUE;
`ifdef CFG_READBACK_EN
          rd_d    = 1'b0;
`endif
        end
      end
      S_ISSUE:    if (bus.cmd_ready) state_d = S_WAIT_RSP;
      S_WAIT_RSP: if (bus.rsp_valid) begin
        if (bus.rsp_nack) fail = 1'b1;
`ifdef CFG_READBACK_EN
        else if (!rd_q) begin
          rd_d    = 1'b1;
          state_d = S_ISSUE;
        end
        else if (bus.rsp_rdata != val_q) fail = 1'b1;
`endif
        else adv = 1'b1;
      end
      S_DELAY:         if (tmr_expired) adv = 1'b1;
      S_DONE, S_ERROR: if (start) kick = 1'b1;
      default:         state_d = S_IDLE;
    endcase

    if (kick) begin
      state_d   = S_RST_HOLD;
      tmr_load  = 1'b1;
      tmr_ms    = 8'(RST_HOLD_MS);
      addr_d    = '0;
      retry_d   = '0;
      err_idx_d = '0;
    end
    if (fail) begin
      if (retry_q == RW'(RETRY_MAX)) begin
        state_d   = S_ERROR;
        err_idx_d = addr_q;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = S_ISSUE;
      end
`ifdef CFG_READBACK_EN
      rd_d = 1'b0;
`endif
    end
    // End marker and last-slot wrap share one path: dev0 hands over to dev1, dev1 finishes.
    if (adv && !last_slot) begin
      addr_d  = addr_q + 1'b1;
      state_d = S_FETCH;
    end else if (adv || tbl_done) begin
      if (addr_q[TBL_AW-1] == DEV_RX) begin
        addr_d  = DEV1_BASE;
        state_d = S_FETCH;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      reg_q     <= '0;
      val_q     <= '0;
      retry_q   <= '0;
      err_idx_q <= '0;
`ifdef CFG_READBACK_EN
      rd_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      reg_q     <= reg_d;
      val_q     <= val_d;
      retry_q   <= retry_d;
      err_idx_q <= err_idx_d;
`ifdef CFG_READBACK_EN
      rd_q      <= rd_d;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst || !busy) begin
      led_cnt_q <= '0;
      led_q     <= 1'b0;
    end else if (ms_tick) begin
      led_cnt_q <= led_cnt_q + 1'b1;
      if (&led_cnt_q) led_q <= ~led_q;
    end
  end

  assign busy      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);
  assign rstn_out  = !(state_q inside {S_IDLE, S_RST_HOLD});
  assign tbl_addr  = addr_q;
  assign err_idx   = err_idx_q;
  assign led_int   = done | led_q;

  // rst gates cmd_valid directly so an in-flight request is withdrawn before the state register clears.
  assign bus.cmd_valid = (state_q == S_ISSUE) && !rst;
  assign bus.cmd_dev   = addr_q[TBL_AW-1] ? TX_DEV_ADDR : RX_DEV_ADDR;
  assign bus.cmd_reg   = reg_q;
  assign bus.cmd_wdata = val_q;
`ifdef CFG_READBACK_EN
  assign bus.cmd_rd    = rd_q;
`else
  logic unused_rdata;
  assign bus.cmd_rd    = 1'b0;
  assign unused_rdata  = ^bus.rsp_rdata;
`endif
endmodule

// File: tb/tb_hdmi_cfg_seq.sv
// Scoreboard bench for hdmi_cfg_seq: 10 cycles per ms, registered table ROM, scripted IIC slave.
module tb_hdmi_cfg_seq;
  localparam int unsigned MS = 10;

  typedef struct packed {
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic       rd;
  } cmd_t;

  typedef struct {
    logic       nack;
    logic [7:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rstn_out, busy, done, error, led_int;
  logic [7:0]  tbl_addr, err_idx;
  logic [15:0] tbl_data;
  logic [15:0] rom [256];

  cmd_t        exp_q[$];
  rsp_t        plan_q[$];
  int unsigned gap_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned stall = 0;
  int unsigned last_rsp_cyc = 0;
  int unsigned n_hs = 0;
  bit          led_busy_seen = 1'b0;

  hdmi_cfg_seq_if bus ();

  hdmi_cfg_seq #(
    .CLK_HZ     (MS * 1000),
    .RST_HOLD_MS(10),
    .RST_WAIT_MS(50),
    .TBL_AW     (8),
    .RETRY_MAX  (3),
    .RX_DEV_ADDR(7'h56),
    .TX_DEV_ADDR(7'h59)
  ) dut (
    .sys_clk (clk),
    .rst     (rst),
    .start   (start),
    .rstn_out(rstn_out),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .err_idx (err_idx),
    .led_int (led_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic exp_cmd(logic [6:0] d, logic [7:0] r, logic [7:0] w);
    cmd_t c;
    c.dev = d; c.rg = r; c.wd = w; c.rd = 1'b0;
    exp_q.push_back(c);
  endtask

  task automatic plan_rsp(logic n);
    rsp_t p;
    p.nack = n; p.rdata = 8'h00;
    plan_q.push_back(p);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(string name, int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected done or error", name, budget);
    end
  endtask

  // Monitor: every handshake is checked against the next expected command.
  cmd_t mon_act, mon_exp;
  initial forever begin
    @(negedge clk);
    if (bus.cmd_valid && bus.cmd_ready) begin
      mon_act = {bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata, bus.cmd_rd};
      n_hs++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected: got %0h expected no command", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("cmd", mon_act, mon_exp);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (busy && led_int) led_busy_seen = 1'b1;
  end

  // Slave: optional one-shot stall on cmd_ready, then a scripted response two cycles after acceptance.
  cmd_t cap;
  bit   stable;
  rsp_t rsp;
  initial begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_nack  = 1'b0;
    bus.rsp_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.cmd_valid && !rst) begin
        gap_q.push_back(cyc - last_rsp_cyc);
        cap    = {bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata, bus.cmd_rd};
        stable = 1'b1;
        for (int i = 0; i < int'(stall); i++) begin
          @(negedge clk);
          if (!bus.cmd_valid || {bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata, bus.cmd_rd} !== cap)
            stable = 1'b0;
        end
        if (stall != 0) chk("stall_stable", stable, 1);
        stall = 0;
        @(posedge clk); #1 bus.cmd_ready = 1'b1;
        @(posedge clk); #1 bus.cmd_ready = 1'b0;
        @(posedge clk);
        if (plan_q.size() != 0) rsp = plan_q.pop_front();
        else begin rsp.nack = 1'b0; rsp.rdata = 8'h00; end
        #1;
        bus.rsp_valid = 1'b1;
        bus.rsp_nack  = rsp.nack;
        bus.rsp_rdata = rsp.rdata;
        last_rsp_cyc  = cyc;
        @(posedge clk); #1;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
      end
    end
  end

  int n, m, hs0;
  logic [7:0] b;
  initial begin
    // T1: single write, reset/settle timing.
    rom_clear();
    rom[0] = 16'h01A5;
    exp_cmd(7'h56, 8'h01, 8'hA5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rstn_out", rstn_out, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_led_int", led_int, 0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      if (!rstn_out) n++;
    end while (!rstn_out && n < 2000);
    // 10 ms hold plus the IDLE cycle and the transition cycle.
    chk_rng("rst_hold_len", n, 101, 103);
    m = 0;
    while (!bus.cmd_valid && m < 2000) begin
      @(negedge clk);
      m++;
    end
    // 50 ms settle plus FETCH/DECODE.
    chk_rng("rst_wait_len", m, 501, 503);
    wait_end("t1", 2000);
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);
    chk("t1_busy", busy, 0);
    chk("t1_led_done", led_int, 1);
    chk("t1_no_led_toggle", led_busy_seen, 0);
    chk("t1_exp_left", exp_q.size(), 0);

    // T2: long cmd_ready stall; both devices; LED blinks while busy.
    rom_clear();
    rom[0]   = 16'h103C;
    rom[128] = 16'h207E;
    exp_cmd(7'h56, 8'h10, 8'h3C);
    exp_cmd(7'h59, 8'h20, 8'h7E);
    stall = 2100;
    led_busy_seen = 1'b0;
    hs0 = n_hs;
    pulse_start();
    @(negedge clk);
    chk("t2_done_clr", done, 0);
    chk("t2_rstn_low", rstn_out, 0);
    wait_end("t2", 6000);
    chk("t2_done", done, 1);
    chk("t2_led_blink", led_busy_seen, 1);
    chk("t2_handshakes", n_hs - hs0, 2);
    chk("t2_exp_left", exp_q.size(), 0);

    // T3a: three NACKs then ACK.
    rom_clear();
    rom[0] = 16'h0511;
    repeat (4) exp_cmd(7'h56, 8'h05, 8'h11);
    repeat (3) plan_rsp(1'b1);
    pulse_start();
    wait_end("t3a", 3000);
    chk("t3a_done", done, 1);
    chk("t3a_error", error, 0);
    chk("t3a_exp_left", exp_q.size(), 0);
    chk("t3a_plan_left", plan_q.size(), 0);

    // T3b: second entry NACKed four times -> error at address 1.
    rom_clear();
    rom[0] = 16'h0622;
    rom[1] = 16'h0733;
    rom[2] = 16'h0844;
    exp_cmd(7'h56, 8'h06, 8'h22);
    repeat (4) exp_cmd(7'h56, 8'h07, 8'h33);
    plan_rsp(1'b0);
    repeat (4) plan_rsp(1'b1);
    pulse_start();
    wait_end("t3b", 3000);
    chk("t3b_error", error, 1);
    chk("t3b_done", done, 0);
    chk("t3b_err_idx", err_idx, 1);
    repeat (200) @(negedge clk);
    chk("t3b_busy", busy, 0);
    chk("t3b_exp_left", exp_q.size(), 0);

    // T4: restart from ERROR; 5 ms delay entry; start while busy ignored.
    rom_clear();
    rom[0] = 16'h0101;
    rom[1] = 16'hFE05;
    rom[2] = 16'h0202;
    exp_cmd(7'h56, 8'h01, 8'h01);
    exp_cmd(7'h56, 8'h02, 8'h02);
    gap_q.delete();
    pulse_start();
    @(negedge clk);
    chk("t4_error_clr", error, 0);
    chk("t4_rstn_low", rstn_out, 0);
    repeat (300) @(negedge clk);
    pulse_start();
    @(negedge clk);
    chk("t4_busy_start_rstn", rstn_out, 1);
    chk("t4_busy_start_busy", busy, 1);
    wait_end("t4", 3000);
    chk("t4_done", done, 1);
    // 50 cycles of delay plus FETCH/DECODE/DELAY-entry and FETCH/DECODE/ISSUE overhead.
    chk_rng("t4_delay_gap", (gap_q.size() > 1) ? int'(gap_q[1]) : 0, 55, 57);
    chk("t4_exp_left", exp_q.size(), 0);

    // T5: both tables full, no end markers; walk stops at the top address.
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      rom[i] = {1'b0, b[6:0], b ^ 8'h5A};
      exp_cmd((i < 128) ? 7'h56 : 7'h59, {1'b0, b[6:0]}, b ^ 8'h5A);
    end
    pulse_start();
    wait_end("t5", 8000);
    chk("t5_done", done, 1);
    chk("t5_tbl_addr_top", tbl_addr, 8'hFF);
    chk("t5_exp_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
